// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: steps a 16-bit one-bit shifter once per clock
// until the requested (clamped) count is exhausted, then pulses done with the result.
module shift_sequencer #(
  parameter int AMT_W     = 5,
  parameter int MAX_SHIFT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      din,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [15:0]      dout
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Single-step shifter; ASR keeps bit 15 so repeated steps sign-fill.
  function automatic logic [15:0] f_shift1(input logic [15:0] a, input logic [1:0] o);
    logic [15:0] r;
    case (o)
      2'b01:   r = {a[14:0], 1'b0};
      2'b10:   r = {1'b0, a[15:1]};
      2'b11:   r = {a[15], a[15:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  state_t           r_state;
  logic [15:0]      r_acc;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_dout;

  logic [CNT_W-1:0] w_cnt_init;
  logic [15:0]      w_acc_next;
  logic             w_skip;

  // Clamp the requested count and precompute the next accumulator value.
  always_comb begin
    w_cnt_init = CNT_W'(amount);
    if (32'(amount) > MAX_SHIFT) begin
      w_cnt_init = CNT_W'(MAX_SHIFT);
    end else begin
      w_cnt_init = CNT_W'(amount);
    end
    w_skip     = (w_cnt_init == {CNT_W{1'b0}}) || (op == 2'b00);
    w_acc_next = f_shift1(r_acc, r_op);
  end

  // Sequencer FSM with registered busy/done/dout.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= 16'h0000;
      r_op    <= 2'b00;
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_acc  <= din;
            r_cnt  <= w_cnt_init;
            r_busy <= 1'b1;
            if (w_skip) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_dout  <= din;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          // Abort wins over stepping: accumulator and dout are left untouched.
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_dout  <= w_acc_next;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, multi-cycle
// corner sequences and randomized requests against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] din;
  logic [1:0]  op;
  logic [4:0]  amount;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.AMT_W(5), .MAX_SHIFT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .din     (din),
    .op      (op),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [4:0]  amt;
    logic [15:0] exp;
    int          edges;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int ref_n(input logic [1:0] o, input logic [4:0] a);
    if (o == 2'b00) return 0;
    return (int'(a) > 16) ? 16 : int'(a);
  endfunction

  // Whole shift computed in one go with wide arithmetic, not step by step.
  function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] d, input logic [4:0] a);
    int n;
    logic [31:0] u;
    logic signed [31:0] s;
    n = ref_n(o, a);
    u = {16'h0000, d};
    s = {{16{d[15]}}, d};
    case (o)
      2'b01:   u = u << n;
      2'b10:   u = u >> n;
      2'b11:   begin s = s >>> n; u = s; end
      default: u = u;
    endcase
    return u[15:0];
  endfunction

  // Issue one request; optionally inject a stray start or an abort at loop step k.
  task automatic do_req(input logic [1:0] o, input logic [15:0] d, input logic [4:0] a,
                        input int inj_at, input int abort_at,
                        output logic [15:0] got, output int edges, output int busy_cyc, output logic ok);
    @(negedge clk);
    start = 1'b1; op = o; din = d; amount = a;
    edges = 0; busy_cyc = 0; ok = 1'b0; got = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start  = 1'b0;
      din    = 16'($urandom);
      op     = 2'($urandom);
      amount = 5'($urandom);
      abort  = (k == abort_at) ? 1'b1 : 1'b0;
      if (k == inj_at) begin
        start = 1'b1; din = 16'hFFFF; op = 2'b10; amount = 5'd1;
      end
      if (busy) busy_cyc++;
      if (done) begin
        got = dout;
        ok  = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t        vecs[10];
  logic [15:0] got;
  int          edges;
  int          bcyc;
  logic        ok;
  logic [15:0] prev;

  initial begin
    vecs[0] = '{2'b01, 16'h0001, 5'd4,  16'h0010, 5};
    vecs[1] = '{2'b11, 16'h8000, 5'd3,  16'hF000, 4};
    vecs[2] = '{2'b10, 16'h8000, 5'd15, 16'h0001, 16};
    vecs[3] = '{2'b00, 16'hA5A5, 5'd7,  16'hA5A5, 1};
    vecs[4] = '{2'b01, 16'hA5A5, 5'd0,  16'hA5A5, 1};
    vecs[5] = '{2'b11, 16'h8000, 5'd20, 16'hFFFF, 17};
    vecs[6] = '{2'b01, 16'h1234, 5'd31, 16'h0000, 17};
    vecs[7] = '{2'b10, 16'hFFFF, 5'd16, 16'h0000, 17};
    vecs[8] = '{2'b11, 16'h7FFF, 5'd16, 16'h0000, 17};
    vecs[9] = '{2'b11, 16'h8001, 5'd1,  16'hC000, 2};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; din = 16'h0; op = 2'b00; amount = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_dout", {16'b0, dout}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].din, vecs[i].amt, -1, -1, got, edges, bcyc, ok);
      chk($sformatf("vec%0d_done", i), {31'b0, ok}, 32'd1);
      chk($sformatf("vec%0d_dout", i), {16'b0, got}, {16'b0, vecs[i].exp});
      chk($sformatf("vec%0d_edges", i), edges, vecs[i].edges);
      chk($sformatf("vec%0d_busy", i), bcyc, vecs[i].edges);
    end

    // Stray start mid-shift must be ignored.
    do_req(2'b01, 16'h0003, 5'd6, 2, -1, got, edges, bcyc, ok);
    chk("midstart_done", {31'b0, ok}, 32'd1);
    chk("midstart_dout", {16'b0, got}, 32'h00C0);
    chk("midstart_edges", edges, 7);
    @(negedge clk);
    chk("midstart_idle", {31'b0, busy}, 32'd0);

    // Abort at step 2 of 6: no done, dout keeps the previous result.
    prev = dout;
    do_req(2'b10, 16'hF0F0, 5'd6, -1, 1, got, edges, bcyc, ok);
    chk("abort_nodone", {31'b0, ok}, 32'd0);
    chk("abort_busy", bcyc, 2);
    chk("abort_dout", {16'b0, dout}, {16'b0, prev});
    chk("abort_idle", {31'b0, busy}, 32'd0);

    // Reset mid-shift discards the operation.
    @(negedge clk);
    start = 1'b1; op = 2'b01; din = 16'h0001; amount = 5'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_dout", {16'b0, dout}, 32'd0);
    reset_n = 1'b1;
    do_req(2'b01, 16'h0001, 5'd2, -1, -1, got, edges, bcyc, ok);
    chk("postrst_done", {31'b0, ok}, 32'd1);
    chk("postrst_dout", {16'b0, got}, 32'h0004);
    chk("postrst_edges", edges, 3);

    // Randomized requests against the arithmetic model.
    for (int r = 0; r < 40; r++) begin
      logic [1:0]  ro;
      logic [15:0] rd;
      logic [4:0]  ra;
      logic [15:0] rexp;
      ro = 2'($urandom);
      rd = 16'($urandom);
      ra = 5'($urandom_range(0, 31));
      rexp = ref_shift(ro, rd, ra);
      do_req(ro, rd, ra, -1, -1, got, edges, bcyc, ok);
      chk($sformatf("rnd%0d_done", r), {31'b0, ok}, 32'd1);
      chk($sformatf("rnd%0d_dout", r), {16'b0, got}, {16'b0, rexp});
      chk($sformatf("rnd%0d_edges", r), edges, ref_n(ro, ra) + 1);
      @(negedge clk);
      chk($sformatf("rnd%0d_hold", r), {16'b0, dout}, {16'b0, rexp});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
